// File: rtl/param_register_file.sv
// Parametrised register file with sequenced init, optional zero register and write-to-read bypass.
// Optional pending-register scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module param_register_file #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic                       ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   init_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   init_val;
    logic                run;
    logic                wr_ok;

    assign run = (state == RUN);

    // Writes to the hardwired zero register never reach storage.
    assign wr_ok = run && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        init_val = '0;
        if (INIT_MODE == 1)
            init_val = DATA_W'(init_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state    <= INIT;
                    init_cnt <= '0;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset: the init engine rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (!run)
            mem[init_cnt] <= init_val;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!run)
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if ((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0))
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W]))
                rd_data[k*DATA_W +: DATA_W] = wr_data;
            else
                rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] pending;

    // Set is applied after clear so a new producer wins over a retiring one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (run) begin
            if (wr_en)
                pending[wr_addr] <= 1'b0;
            if (rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0)))
                pending[rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = run && pending[rd_addr[k*ADDR_W +: ADDR_W]];
            if ((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0))
                rd_busy[k] = 1'b0;
            if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W]))
                rd_busy[k] = 1'b0;
        end
    end
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_en, rsv_addr};
    assign rd_busy    = '0;
`endif

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default instance, a no-bypass instance and a 3-port instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        ready;

    logic [4:0]  rd_addr_nb;
    logic [31:0] rd_data_nb;
    logic [0:0]  rd_busy_nb;
    logic        ready_nb;

    logic [14:0] rd_addr_m;
    logic [95:0] rd_data_m;
    logic [2:0]  rd_busy_m;
    logic        ready_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_register_file dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_busy(rd_busy), .ready(ready)
    );

    param_register_file #(.NUM_RD(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_nb), .rd_data(rd_data_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_busy(rd_busy_nb), .ready(ready_nb)
    );

    param_register_file #(.NUM_RD(3)) dut_m (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_m), .rd_data(rd_data_m),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_busy(rd_busy_m), .ready(ready_m)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Releases reset and walks the full init sequence, checking that nothing is visible before ready.
    task automatic run_init(input int first_cycle);
        for (int i = 0; i < 32; i++) begin
            if (i == first_cycle) begin
                wr_en   = 1'b1;
                wr_addr = 5'd3;
                wr_data = 32'h0000_0BAD;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            check("init_ready", 64'(ready), 64'd0);
            check("init_rd0", 64'(rd_data[31:0]), 64'd0);
            check("init_rd1", 64'(rd_data[63:32]), 64'd0);
            check("init_busy", 64'(rd_busy), 64'd0);
            @(posedge clk);
        end
        #1;
        wr_en = 1'b0;
        check("ready_up", 64'(ready), 64'd1);
        check("ready_up_m", 64'(ready_m), 64'd1);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rd_addr = {5'd31, 5'd5}; rd_addr_nb = 5'd7; rd_addr_m = {5'd2, 5'd1, 5'd1};

        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 64'(ready), 64'd0);
            check("rst_rd", rd_data, 64'd0);
            check("rst_busy", 64'(rd_busy), 64'd0);
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        run_init(-1);
        @(negedge clk);
        check("init_val5", 64'(rd_data[31:0]), 64'h5);
        check("init_val31", 64'(rd_data[63:32]), 64'h1F);
        check("init_val7_nb", 64'(rd_data_nb), 64'h7);

        // Write reg 7, checking same-cycle bypass on both variants
        next_cycle();
        rd_addr = {5'd5, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("byp_same", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        check("nobyp_same", 64'(rd_data_nb), 64'h7);
        check("byp_other", 64'(rd_data[63:32]), 64'h5);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("wr_next", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        check("wr_next_nb", 64'(rd_data_nb), 64'hDEAD_BEEF);

        // Zero register ignores writes, including during the write cycle
        next_cycle();
        rd_addr = {5'd0, 5'd0};
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        @(negedge clk);
        check("zero_during", rd_data, 64'd0);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("zero_after", rd_data, 64'd0);

        // Pending scoreboard
        next_cycle();
        rd_addr = {5'd0, 5'd9};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        @(negedge clk);
        check("rsv_same", 64'(rd_busy), 64'd0);
        next_cycle();
        rsv_en = 1'b0;
        @(negedge clk);
`ifdef REGFILE_SCOREBOARD_EN
        check("rsv_next", 64'(rd_busy), 64'b01);
`else
        check("rsv_off", 64'(rd_busy), 64'd0);
`endif
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_00A5;
        @(negedge clk);
        check("wr9_busy", 64'(rd_busy), 64'd0);
        check("wr9_data", 64'(rd_data[31:0]), 64'hA5);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("wr9_clear", 64'(rd_busy), 64'd0);
        check("wr9_read", 64'(rd_data[31:0]), 64'hA5);
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_00C3;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        @(negedge clk);
        check("both_same", 64'(rd_busy), 64'd0);
        next_cycle();
        wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd0;
        @(negedge clk);
`ifdef REGFILE_SCOREBOARD_EN
        check("both_after", 64'(rd_busy), 64'b01);
`else
        check("both_off", 64'(rd_busy), 64'd0);
`endif
        check("both_data", 64'(rd_data[31:0]), 64'hC3);
        next_cycle();
        rsv_en = 1'b0;
        @(negedge clk);
        check("rsv_zero", 64'(rd_busy[1]), 64'd0);

        // Multi-port instance with bypass on two ports
        next_cycle();
        rd_addr_m = {5'd2, 5'd1, 5'd1};
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h55;
        @(negedge clk);
        check("mp_port0", 64'(rd_data_m[31:0]), 64'h55);
        check("mp_port1", 64'(rd_data_m[63:32]), 64'h55);
        check("mp_port2", 64'(rd_data_m[95:64]), 64'h2);
        next_cycle();
        wr_en = 1'b0;

        // Reset during INIT restarts the whole sequence
        reset = 1'b1;
        #1;
        check("rst_async", 64'(ready), 64'd0);
        next_cycle();
        reset = 1'b0;
        rd_addr = {5'd7, 5'd3};
        repeat (10) next_cycle();
        check("mid_init", 64'(ready), 64'd0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        run_init(4);
        @(negedge clk);
        check("reinit_reg3", 64'(rd_data[31:0]), 64'h3);
        check("reinit_reg7", 64'(rd_data[63:32]), 64'h7);
        check("reinit_busy", 64'(rd_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
